// File: rtl/root_output_unit_mc.sv
// Root-node output unit: round-robin arbitration of NUM_SRC controllers onto the router LOCAL port,
// read-response buffering to the primary read port, and serialised upstream credit return.
// Latency: grant->out_data 1 cycle; read flit->read_data_vld 3 cycles min; credit event->upstream pulse 1 cycle.
module root_output_unit_mc #(
  parameter int NUM_SRC        = 2,
  parameter int FLIT_WIDTH     = 36,
  parameter int INFO_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int READ_ADDR_BITS = 12,
  parameter int CREDIT_DEPTH   = 8,
  parameter logic [INFO_WIDTH-1:0] READ_INFO = INFO_WIDTH'(2),
  localparam int RW = READ_ADDR_BITS + DATA_WIDTH,
  localparam int CW = $clog2(CREDIT_DEPTH + 1),
  localparam int PW = $clog2(2 * CREDIT_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC*FLIT_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_gnt,
  output logic                          router_rdy,
  output logic [CW-1:0]                 credit_count,
  input  logic                          downstream_credit,
  output logic                          out_data_valid,
  output logic [FLIT_WIDTH-1:0]         out_data,
  input  logic                          in_data_valid,
  input  logic [FLIT_WIDTH-1:0]         in_data,
  output logic                          upstream_credit,
  input  logic                          read_data_rdy,
  output logic                          read_data_vld,
  output logic [RW-1:0]                 read_data,
  output logic                          err_overflow
);

  localparam int PTRW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int AW   = (CREDIT_DEPTH > 1) ? $clog2(CREDIT_DEPTH) : 1;

  logic [FLIT_WIDTH-1:0] src_flit [NUM_SRC];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_flit[i] = src_data[i*FLIT_WIDTH +: FLIT_WIDTH];
  end

  // Only the kept address LSBs and the data field reach the read payload.
  logic unused_in_bits;
  assign unused_in_bits = ^in_data;

  logic [PTRW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  out_vld_q, out_vld_d;
  logic [FLIT_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  err_q, err_d;
  logic                  wr_vld_q, wr_vld_d;
  logic [RW-1:0]         wr_dat_q, wr_dat_d;
  logic [RW-1:0]         mem_q [CREDIT_DEPTH];
  logic [RW-1:0]         mem_d [CREDIT_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [RW-1:0]         rd_dat_q, rd_dat_d;
  logic [PW-1:0]         pend_q, pend_d;
  logic                  uc_q, uc_d;

  logic                  gnt_any;
  logic [FLIT_WIDTH-1:0] gnt_dat;
  logic [PTRW-1:0]       idx_v;
  int                    idx;
  logic                  in_read, in_nonread, pop, wr_ok;
  logic [PW-1:0]         pend_sum;

  // Round-robin scan starting at ptr; no grant while out of downstream credits.
  always_comb begin
    src_gnt = '0;
    gnt_any = 1'b0;
    gnt_dat = '0;
    ptr_d   = ptr_q;
    idx     = 0;
    idx_v   = '0;
    if (credit_q != '0) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        idx_v = PTRW'(idx);
        if (!gnt_any && src_req[idx_v]) begin
          gnt_any        = 1'b1;
          src_gnt[idx_v] = 1'b1;
          gnt_dat        = src_flit[idx_v];
          ptr_d          = (idx == NUM_SRC - 1) ? '0 : PTRW'(idx + 1);
        end
      end
    end
  end

  // Downstream credit counter, output flit register and the sticky error flag.
  always_comb begin
    credit_d  = credit_q;
    err_d     = err_q;
    out_vld_d = gnt_any;
    out_dat_d = gnt_any ? gnt_dat : '0;
    if (gnt_any && !downstream_credit) begin
      credit_d = credit_q - CW'(1);
    end else if (!gnt_any && downstream_credit) begin
      if (credit_q == CW'(CREDIT_DEPTH)) err_d = 1'b1;
      else                               credit_d = credit_q + CW'(1);
    end
    if (wr_vld_q && !wr_ok) err_d = 1'b1;
  end

  // Inbound decode, read FIFO and the hold-semantics read output register.
  always_comb begin
    in_read    = in_data_valid && (in_data[FLIT_WIDTH-1 -: INFO_WIDTH] == READ_INFO);
    in_nonread = in_data_valid && !in_read;
    wr_vld_d   = in_read;
    wr_dat_d   = in_read ? {in_data[DATA_WIDTH +: READ_ADDR_BITS], in_data[DATA_WIDTH-1:0]} : '0;
    wr_ok      = wr_vld_q && (cnt_q != CW'(CREDIT_DEPTH));
    pop        = (cnt_q != '0) && (!rd_vld_q || read_data_rdy);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_vld_d   = rd_vld_q;
    rd_dat_d   = rd_dat_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wr_dat_q;
      wr_ptr_d = (wr_ptr_q == AW'(CREDIT_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_vld_d = 1'b1;
      rd_dat_d = mem_q[rd_ptr_q];
      rd_ptr_d = (rd_ptr_q == AW'(CREDIT_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end else if (rd_vld_q && read_data_rdy) begin
      rd_vld_d = 1'b0;
      rd_dat_d = '0;
    end
    cnt_d = cnt_q + CW'(wr_ok) - CW'(pop);
  end

  // Credit serialiser: this cycle's events count toward the pulse issued at the next edge.
  always_comb begin
    pend_sum = pend_q + PW'(in_nonread) + PW'(pop);
    uc_d     = (pend_sum != '0);
    pend_d   = pend_sum - PW'(uc_d);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      credit_q  <= CW'(CREDIT_DEPTH);
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      err_q     <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_dat_q  <= '0;
      for (int i = 0; i < CREDIT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_dat_q  <= '0;
      pend_q    <= '0;
      uc_q      <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      err_q     <= err_d;
      wr_vld_q  <= wr_vld_d;
      wr_dat_q  <= wr_dat_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_dat_q  <= rd_dat_d;
      pend_q    <= pend_d;
      uc_q      <= uc_d;
    end
  end

  assign credit_count    = credit_q;
  assign router_rdy      = (credit_q != '0);
  assign out_data_valid  = out_vld_q;
  assign out_data        = out_dat_q;
  assign upstream_credit = uc_q;
  assign read_data_vld   = rd_vld_q;
  assign read_data       = rd_dat_q;
  assign err_overflow    = err_q;

endmodule

// File: tb/tb_root_output_unit_mc.sv
// Directed bench for root_output_unit_mc with default parameters.
// Inputs change 1ns after posedge; outputs sampled 1ns after posedge or at negedge.
module tb_root_output_unit_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_req;
  logic [71:0] src_data;
  logic [1:0]  src_gnt;
  logic        router_rdy;
  logic [3:0]  credit_count;
  logic        downstream_credit;
  logic        out_data_valid;
  logic [35:0] out_data;
  logic        in_data_valid;
  logic [35:0] in_data;
  logic        upstream_credit;
  logic        read_data_rdy;
  logic        read_data_vld;
  logic [27:0] read_data;
  logic        err_overflow;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [35:0] FLIT0 = 36'hA_0001_1111;
  localparam logic [35:0] FLIT1 = 36'hB_0002_2222;

  root_output_unit_mc dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_data(src_data), .src_gnt(src_gnt),
    .router_rdy(router_rdy), .credit_count(credit_count),
    .downstream_credit(downstream_credit),
    .out_data_valid(out_data_valid), .out_data(out_data),
    .in_data_valid(in_data_valid), .in_data(in_data),
    .upstream_credit(upstream_credit),
    .read_data_rdy(read_data_rdy), .read_data_vld(read_data_vld), .read_data(read_data),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [35:0] exp_flit;
    rst = 1'b1; src_req = '0; src_data = {FLIT1, FLIT0}; downstream_credit = 1'b0;
    in_data_valid = 1'b0; in_data = '0; read_data_rdy = 1'b0;
    tick(); tick();
    chk("rst_credit", 64'(credit_count), 64'd8);
    chk("rst_rdy", 64'(router_rdy), 64'd1);
    chk("rst_out_vld", 64'(out_data_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_uc", 64'(upstream_credit), 64'd0);
    chk("rst_rd_vld", 64'(read_data_vld), 64'd0);
    chk("rst_rd_data", 64'(read_data), 64'd0);
    chk("rst_err", 64'(err_overflow), 64'd0);
    rst = 1'b0;
    tick();

    // Both sources requesting: grants alternate until credits run out.
    src_req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_gnt", 64'(src_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      exp_flit = (i % 2 == 0) ? FLIT0 : FLIT1;
      chk("rr_out_vld", 64'(out_data_valid), 64'd1);
      chk("rr_out_data", 64'(out_data), 64'(exp_flit));
      chk("rr_credit", 64'(credit_count), 64'(7 - i));
    end
    @(negedge clk);
    chk("empty_gnt", 64'(src_gnt), 64'd0);
    chk("empty_rdy", 64'(router_rdy), 64'd0);
    tick();
    chk("empty_out_vld", 64'(out_data_valid), 64'd0);
    chk("empty_out_data", 64'(out_data), 64'd0);
    chk("empty_credit", 64'(credit_count), 64'd0);

    // Credit return at zero credits together with a request.
    src_req = 2'b01; downstream_credit = 1'b1;
    @(negedge clk);
    chk("ret_gnt0", 64'(src_gnt), 64'd0);
    tick();
    downstream_credit = 1'b0;
    chk("ret_credit1", 64'(credit_count), 64'd1);
    @(negedge clk);
    chk("ret_gnt1", 64'(src_gnt), 64'd1);
    tick();
    src_req = '0;
    chk("ret_credit0", 64'(credit_count), 64'd0);
    chk("ret_out_vld", 64'(out_data_valid), 64'd1);
    chk("ret_out_data", 64'(out_data), 64'(FLIT0));
    tick();
    chk("ret_out_idle", 64'(out_data_valid), 64'd0);

    // Three non-read flits -> three consecutive credit pulses.
    in_data_valid = 1'b1; in_data = {4'd0, 16'h1234, 16'h5678};
    chk("nr_uc_pre", 64'(upstream_credit), 64'd0);
    tick(); chk("nr_uc_a", 64'(upstream_credit), 64'd1);
    tick(); chk("nr_uc_b", 64'(upstream_credit), 64'd1);
    tick(); in_data_valid = 1'b0;
    chk("nr_uc_c", 64'(upstream_credit), 64'd1);
    tick(); chk("nr_uc_end", 64'(upstream_credit), 64'd0);

    // Single read flit held by the consumer.
    in_data_valid = 1'b1; in_data = {4'd2, 16'hF123, 16'h00AB};
    tick(); in_data_valid = 1'b0;
    chk("rd_vld_p1", 64'(read_data_vld), 64'd0);
    tick();
    chk("rd_vld_p2", 64'(read_data_vld), 64'd0);
    chk("rd_uc_p2", 64'(upstream_credit), 64'd0);
    tick();
    chk("rd_vld", 64'(read_data_vld), 64'd1);
    chk("rd_data", 64'(read_data), 64'h123_00AB);
    chk("rd_uc_pulse", 64'(upstream_credit), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rd_hold_vld", 64'(read_data_vld), 64'd1);
      chk("rd_hold_data", 64'(read_data), 64'h123_00AB);
      chk("rd_hold_uc", 64'(upstream_credit), 64'd0);
    end
    read_data_rdy = 1'b1;
    tick();
    read_data_rdy = 1'b0;
    chk("rd_acc_vld", 64'(read_data_vld), 64'd0);
    chk("rd_acc_data", 64'(read_data), 64'd0);
    chk("rd_acc_uc", 64'(upstream_credit), 64'd0);

    // Non-read arrival in the same cycle as a FIFO pop.
    read_data_rdy = 1'b1;
    in_data_valid = 1'b1; in_data = {4'd2, 16'h0456, 16'h7777};
    tick(); in_data_valid = 1'b0;
    tick(); in_data_valid = 1'b1; in_data = {4'd1, 16'h0000, 16'h0000};
    tick(); in_data_valid = 1'b0;
    chk("dual_uc_a", 64'(upstream_credit), 64'd1);
    chk("dual_vld", 64'(read_data_vld), 64'd1);
    chk("dual_data", 64'(read_data), 64'h456_7777);
    tick();
    chk("dual_uc_b", 64'(upstream_credit), 64'd1);
    chk("dual_vld_off", 64'(read_data_vld), 64'd0);
    tick();
    chk("dual_uc_end", 64'(upstream_credit), 64'd0);
    read_data_rdy = 1'b0;

    // Ten read flits against a stalled consumer: the tenth overflows.
    for (int k = 1; k <= 10; k++) begin
      in_data_valid = 1'b1;
      in_data = {4'd2, 16'h0100 + 16'(k), 16'h1000 + 16'(k)};
      tick();
    end
    in_data_valid = 1'b0;
    chk("ovf_err_pre", 64'(err_overflow), 64'd0);
    tick();
    chk("ovf_err", 64'(err_overflow), 64'd1);
    chk("ovf_head_vld", 64'(read_data_vld), 64'd1);
    chk("ovf_head_data", 64'(read_data), 64'h101_1001);
    read_data_rdy = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("drain_vld", 64'(read_data_vld), 64'd1);
      chk("drain_data", 64'(read_data), 64'({12'h100 + 12'(k), 16'h1000 + 16'(k)}));
    end
    tick();
    chk("drain_done", 64'(read_data_vld), 64'd0);
    chk("drain_err_sticky", 64'(err_overflow), 64'd1);
    read_data_rdy = 1'b0;

    // Reset clears the sticky flag and any pending credits.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err", 64'(err_overflow), 64'd0);
    chk("rst2_credit", 64'(credit_count), 64'd8);
    tick();
    chk("rst2_uc", 64'(upstream_credit), 64'd0);
    chk("rst2_rd_vld", 64'(read_data_vld), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/root_output_unit_mc.md
Name: root_output_unit_mc

Overview:
Parametrised, multi-source successor to the root-node output unit of the quadtree accelerator. It arbitrates round-robin among NUM_SRC root controllers onto the root router's LOCAL input port, under downstream credit flow control. It sinks flits from that port: non-read flits are consumed and credited back at once, read flits are buffered and drained to the primary read port under a true valid/ready hold handshake. Upstream credits are serialised so simultaneous credit events are never lost.

Parameters:
NUM_SRC, 2, number of transmitting controllers (>=1)
FLIT_WIDTH, 36, router flit width; must equal INFO_WIDTH+ADDR_WIDTH+DATA_WIDTH
INFO_WIDTH, 4, route-info field width (flit MSBs)
ADDR_WIDTH, 16, route-address field width (middle field)
DATA_WIDTH, 16, route-data field width (flit LSBs)
READ_ADDR_BITS, 12, address LSBs kept in read payload
CREDIT_DEPTH, 8, downstream credits and read FIFO depth (power of 2)
READ_INFO, 4'd2, route-info code identifying a read-response flit
Derived: RW = READ_ADDR_BITS+DATA_WIDTH; CW = clog2(CREDIT_DEPTH+1); PW = clog2(2*CREDIT_DEPTH+1)

Ports:
clk  in  1  system clock
rst  in  1  reset
src_req  in  NUM_SRC  per-source transmit request
src_data  in  NUM_SRC*FLIT_WIDTH  per-source flit, source i at [i*FLIT_WIDTH +: FLIT_WIDTH]
src_gnt  out  NUM_SRC  one-hot grant, combinational
router_rdy  out  1  credit_count > 0
credit_count  out  CW  available downstream credits
downstream_credit  in  1  one credit returned by router
out_data_valid  out  1  flit valid to router
out_data  out  FLIT_WIDTH  flit to router
in_data_valid  in  1  flit valid from router
in_data  in  FLIT_WIDTH  flit from router
upstream_credit  out  1  one-cycle credit pulse to router
read_data_rdy  in  1  primary read consumer ready
read_data_vld  out  1  primary read valid
read_data  out  RW  primary read payload
err_overflow  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst asynchronous, active-high; clock clk): credit_count=CREDIT_DEPTH, rr pointer=0, out_data_valid=0, out_data=0, upstream_credit=0, pending=0, FIFO empty, read_data_vld=0, read_data=0, err_overflow=0. Reset mid-operation discards buffered reads and pending credits.
- Arbiter: when credit_count==0, src_gnt=0. Otherwise grant the first requesting index scanning ptr, ptr+1, ... wrapping mod NUM_SRC. On grant, ptr <= granted+1 (wraps to 0). Sources hold req/data until granted; grant is a one-cycle transfer.
- Output: registered, latency 1. out_data_valid <= |src_gnt; out_data <= granted src_data, else 0.
- Credit counter: grant only -> -1; downstream_credit only -> +1; both -> hold. downstream_credit while credit_count==CREDIT_DEPTH (without a grant) -> hold, set err_overflow.
- Inbound decode: info=in_data[FLIT_WIDTH-1 -: INFO_WIDTH], addr=next ADDR_WIDTH bits, data=low DATA_WIDTH bits. Valid non-read flit -> one credit event. Valid read flit -> registered FIFO write next cycle of {addr[READ_ADDR_BITS-1:0], data}. Write while FIFO full -> flit dropped, err_overflow set.
- Read output stage: single register with hold semantics. Pop FIFO when FIFO non-empty and (!read_data_vld or read_data_rdy). Popped entry loads read_data/read_data_vld=1 next cycle. read_data/read_data_vld stay stable while vld&&!rdy. On vld&&rdy with no pop, vld->0 and data->0. Each pop is one credit event.
- Credit return: pending (PW bits) += number of credit events this cycle (0..2); when pending>0, upstream_credit <= 1 and pending decrements. Net update pending <= pending + events - (pending>0). Minimum latency: event -> pulse next cycle. Back-to-back events produce consecutive pulses, none lost.
- err_overflow clears only on rst.

Test Plan:
- Reset, then src_req=2'b11 held, 8 credits, no downstream_credit -> grants alternate 0,1,0,1..., exactly 8 out_data_valid pulses, then credit_count=0, router_rdy=0, src_gnt=0.
- credit_count=0, pulse downstream_credit and src_req=1 in same cycle -> count stays 0 for that cycle's grant check, becomes 1 next cycle, one grant follows, count returns to 0.
- in_data valid non-read (info=0) 3 consecutive cycles -> upstream_credit high 3 consecutive cycles, starting 1 cycle after the first flit.
- read flit addr=16'hF123, data=16'h00AB with read_data_rdy=0 -> read_data_vld=1, read_data=28'h123_00AB held 10 cycles; rdy=1 -> accepted, vld drops next cycle; exactly one upstream_credit pulse, issued after the pop.
- Same-cycle non-read arrival and FIFO pop -> two upstream_credit pulses on consecutive cycles.
- 9 read flits with rdy=0 (depth 8, output stage holding first) -> 9th accepted; a 10th overflows -> dropped, err_overflow=1 until rst.
